// File: rtl/ibuf2ddr.sv
// ibuf2ddr: drains one PE index buffer into packed DDR words over valid/ready.
// Entries are read in address order, optionally half-swapped, and packed
// IDX_BATCH per word. The final partial word is zero-filled.
// Optional feature macro: IBUF2DDR_LAST_EN adds o_ddr_last, which flags the final word.
module ibuf2ddr #(
  parameter int IDX_W     = 16,
  parameter int DDR_W     = 512,
  parameter int IDX_DEPTH = 256,
  parameter int ADDR_W    = $clog2(IDX_DEPTH),
  parameter int PE_NUM    = 32,
  parameter int SEL_W     = $clog2(PE_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  output logic                      o_done,
  input  logic [3:0]                i_conf_mode,
  input  logic [7:0]                i_conf_idx_num,
  input  logic [SEL_W-1:0]          i_conf_pe_sel,
  output logic                      o_idx_rd_en,
  output logic [ADDR_W-1:0]         o_idx_rd_addr,
  input  logic [PE_NUM*IDX_W*2-1:0] i_idx_rd_data,
  output logic [DDR_W-1:0]          o_ddr_data,
  output logic                      o_ddr_valid,
`ifdef IBUF2DDR_LAST_EN
  output logic                      o_ddr_last,
`endif
  input  logic                      i_ddr_ready
);

  localparam int ENT_W     = 2 * IDX_W;
  localparam int IDX_BATCH = DDR_W / IDX_W / 2;
  localparam int LANE_W    = (IDX_BATCH > 1) ? $clog2(IDX_BATCH) : 1;
  localparam int CNT_W     = $clog2(IDX_BATCH + 2);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t              r_state, w_state_next;
  logic [7:0]          r_n;
  logic [3:0]          r_mode;
  logic [SEL_W-1:0]    r_sel;
  logic [8:0]          r_rd_cnt;
  logic [LANE_W-1:0]   r_lane;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [LANE_W-1:0]   r_iss_lane;
  logic                r_iss_last;
  logic                r_cap_vld;
  logic [LANE_W-1:0]   r_cap_lane;
  logic                r_cap_last;
  logic [DDR_W-1:0]    r_pack;
  logic [CNT_W-1:0]    r_pack_cnt;
  logic                r_pack_final;
  logic [DDR_W-1:0]    r_out_data;
  logic                r_out_valid;
  logic                r_out_final;
  logic                r_done;

  logic [ENT_W-1:0]    w_pe_data;
  logic [ENT_W-1:0]    w_entry;
  logic [DDR_W-1:0]    w_pack_data;
  logic [CNT_W-1:0]    w_pack_cnt;
  logic [CNT_W-1:0]    w_pack_keep;
  logic                w_pack_final;
  logic                w_pack_done;
  logic                w_accept;
  logic                w_move;
  logic                w_issue;
  logic                w_start_go;
  logic                w_unused_mode;

  assign w_unused_mode = ^{i_conf_mode[3], i_conf_mode[0], r_mode[3], r_mode[0]};

  // Read data for the selected PE, halves swapped when the layer mode asks for it.
  assign w_pe_data = i_idx_rd_data[r_sel*ENT_W +: ENT_W];
  assign w_entry   = (r_mode[2:1] == 2'b01) ? {w_pe_data[IDX_W-1:0], w_pe_data[ENT_W-1:IDX_W]}
                                            : w_pe_data;

  // Pack contents including the entry arriving this cycle, lane by lane.
  generate
    for (genvar gi = 0; gi < IDX_BATCH; gi++) begin : g_lane
      assign w_pack_data[gi*ENT_W +: ENT_W] =
        (r_cap_vld && (r_cap_lane == LANE_W'(gi))) ? w_entry : r_pack[gi*ENT_W +: ENT_W];
    end
  endgenerate

  assign w_pack_cnt   = r_pack_cnt + CNT_W'(r_cap_vld);
  assign w_pack_final = r_pack_final | (r_cap_vld & r_cap_last);
  assign w_pack_done  = (w_pack_cnt == CNT_W'(IDX_BATCH)) | w_pack_final;
  assign w_accept     = r_out_valid & i_ddr_ready;
  assign w_move       = w_pack_done & (~r_out_valid | i_ddr_ready);
  assign w_pack_keep  = w_move ? '0 : w_pack_cnt;
  assign w_start_go   = i_start & (i_conf_idx_num != 8'd0);

  // Next state and read issue; a read is issued only if the pack has a free lane
  // once every read already in flight has landed.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    if (i_start) begin
      if (i_conf_idx_num == 8'd0)      w_state_next = S_IDLE;
      else if (i_conf_idx_num == 8'd1) w_state_next = S_DRAIN;
      else                             w_state_next = S_READ;
    end else begin
      case (r_state)
        S_READ: begin
          if ((w_pack_keep + CNT_W'(r_rd_en)) < CNT_W'(IDX_BATCH)) begin
            w_issue = 1'b1;
            if ((r_rd_cnt + 9'd1) == {1'b0, r_n}) w_state_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_accept && r_out_final) w_state_next = S_IDLE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Read pipeline, pack register and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n <= '0; r_mode <= '0; r_sel <= '0;
      r_rd_cnt <= '0; r_lane <= '0; r_rd_en <= 1'b0; r_rd_addr <= '0;
      r_iss_lane <= '0; r_iss_last <= 1'b0;
      r_cap_vld <= 1'b0; r_cap_lane <= '0; r_cap_last <= 1'b0;
      r_pack <= '0; r_pack_cnt <= '0; r_pack_final <= 1'b0;
      r_out_data <= '0; r_out_valid <= 1'b0; r_out_final <= 1'b0;
      r_done <= 1'b1;
    end else if (i_start) begin
      // Fresh (or aborting) start: drop everything in flight and issue address 0.
      r_n <= i_conf_idx_num; r_mode <= i_conf_mode; r_sel <= i_conf_pe_sel;
      r_rd_en <= w_start_go; r_rd_addr <= '0;
      r_rd_cnt <= w_start_go ? 9'd1 : 9'd0;
      r_lane <= LANE_W'(1 % IDX_BATCH);
      r_iss_lane <= '0; r_iss_last <= (i_conf_idx_num == 8'd1);
      r_cap_vld <= 1'b0; r_cap_lane <= '0; r_cap_last <= 1'b0;
      r_pack <= '0; r_pack_cnt <= '0; r_pack_final <= 1'b0;
      r_out_valid <= 1'b0; r_out_final <= 1'b0;
      r_done <= ~w_start_go;
    end else begin
      r_rd_en    <= w_issue;
      r_cap_vld  <= r_rd_en;
      r_cap_lane <= r_iss_lane;
      r_cap_last <= r_iss_last;
      if (w_issue) begin
        r_rd_addr  <= ADDR_W'(r_rd_cnt);
        r_rd_cnt   <= r_rd_cnt + 9'd1;
        r_lane     <= (r_lane == LANE_W'(IDX_BATCH - 1)) ? '0 : r_lane + LANE_W'(1);
        r_iss_lane <= r_lane;
        r_iss_last <= ((r_rd_cnt + 9'd1) == {1'b0, r_n});
      end
      if (w_move) begin
        r_pack <= '0; r_pack_cnt <= '0; r_pack_final <= 1'b0;
        r_out_data <= w_pack_data; r_out_valid <= 1'b1; r_out_final <= w_pack_final;
      end else begin
        r_pack <= w_pack_data; r_pack_cnt <= w_pack_cnt; r_pack_final <= w_pack_final;
        if (w_accept) begin
          r_out_valid <= 1'b0; r_out_final <= 1'b0;
        end
      end
      r_done <= (w_state_next == S_IDLE);
    end
  end

  assign o_done        = r_done;
  assign o_idx_rd_en   = r_rd_en;
  assign o_idx_rd_addr = r_rd_addr;
  assign o_ddr_data    = r_out_data;
  assign o_ddr_valid   = r_out_valid;
`ifdef IBUF2DDR_LAST_EN
  assign o_ddr_last    = r_out_final;
`endif

endmodule

// File: tb/tb_ibuf2ddr.sv
// Bench for ibuf2ddr: table of transfers checked against a word-level model,
// plus hand sequences for abort and mid-transfer reset.
module tb_ibuf2ddr;
  localparam int IDX_W = 16, DDR_W = 512, PE_NUM = 32, SEL_W = 5, ADDR_W = 8;
  localparam int E = 2 * IDX_W, B = DDR_W / E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, i_start, o_done, o_idx_rd_en, o_ddr_valid, i_ddr_ready;
  logic [3:0]           i_conf_mode;
  logic [7:0]           i_conf_idx_num;
  logic [SEL_W-1:0]     i_conf_pe_sel;
  logic [ADDR_W-1:0]    o_idx_rd_addr;
  logic [PE_NUM*E-1:0]  i_idx_rd_data;
  logic [DDR_W-1:0]     o_ddr_data;
`ifdef IBUF2DDR_LAST_EN
  logic                 o_ddr_last;
`endif

  ibuf2ddr dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_done(o_done),
    .i_conf_mode(i_conf_mode), .i_conf_idx_num(i_conf_idx_num), .i_conf_pe_sel(i_conf_pe_sel),
    .o_idx_rd_en(o_idx_rd_en), .o_idx_rd_addr(o_idx_rd_addr), .i_idx_rd_data(i_idx_rd_data),
    .o_ddr_data(o_ddr_data), .o_ddr_valid(o_ddr_valid),
`ifdef IBUF2DDR_LAST_EN
    .o_ddr_last(o_ddr_last),
`endif
    .i_ddr_ready(i_ddr_ready)
  );

  logic [E-1:0] mem [PE_NUM][256];

  // Index buffers: one-cycle read latency, all PEs read in parallel.
  always @(posedge clk) begin
    if (o_idx_rd_en)
      for (int p = 0; p < PE_NUM; p++) i_idx_rd_data[p*E +: E] <= mem[p][o_idx_rd_addr];
  end

  int n_checks = 0, n_err = 0;
  logic [DDR_W-1:0] exp_q [$];
  logic [DDR_W-1:0] last_word;

  task automatic chk(input string name, input logic [DDR_W-1:0] got, input logic [DDR_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected word stream: entry i goes to word i/B, lane i%B; missing lanes are zero.
  task automatic build_model(input int n, input logic [3:0] mode, input int sel);
    logic [DDR_W-1:0] word;
    logic [E-1:0] ent;
    exp_q.delete();
    for (int w = 0; w < (n + B - 1) / B; w++) begin
      word = '0;
      for (int k = 0; k < B; k++) begin
        if (w * B + k < n) begin
          ent = mem[sel][w * B + k];
          if (mode[2:1] == 2'b01) ent = {ent[IDX_W-1:0], ent[E-1:IDX_W]};
          word[k*E +: E] = ent;
        end
      end
      exp_q.push_back(word);
    end
  endtask

  task automatic run_xfer(input int n, input logic [3:0] mode, input int sel, input int pct,
                          input int words, input string tag);
    int cyc, got, next_addr, limit;
    bit first, hold;
    logic [DDR_W-1:0] hold_data;
    build_model(n, mode, sel);
    i_conf_idx_num = n[7:0];
    i_conf_mode    = mode;
    i_conf_pe_sel  = sel[SEL_W-1:0];
    i_start        = 1'b1;
    i_ddr_ready    = (pct == 100);
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1; got = 0; next_addr = 0; first = 1'b1; hold = 1'b0; hold_data = '0;
    limit = (words == 0) ? 10 : 6000;
    chk({tag, "_done_after_start"}, o_done, (n == 0));
    chk({tag, "_valid_after_start"}, o_ddr_valid, 1'b0);
    while (cyc < limit) begin
      if (o_idx_rd_en) begin
        chk($sformatf("%s_rd_addr%0d", tag, next_addr), o_idx_rd_addr, next_addr[7:0]);
        next_addr++;
      end
      if (hold) begin
        chk({tag, "_hold_valid"}, o_ddr_valid, 1'b1);
        chk({tag, "_hold_data"}, o_ddr_data, hold_data);
      end
      if (o_ddr_valid && first) begin
        first = 1'b0;
        if (pct == 100 && n >= B) chk({tag, "_latency"}, cyc, B + 2);
      end
      i_ddr_ready = ($urandom_range(99) < pct);
      if (o_ddr_valid && i_ddr_ready) begin
        if (got < exp_q.size()) chk($sformatf("%s_word%0d", tag, got), o_ddr_data, exp_q[got]);
        else chk({tag, "_extra_word"}, got + 1, exp_q.size());
`ifdef IBUF2DDR_LAST_EN
        chk({tag, "_last"}, o_ddr_last, (got == words - 1));
`endif
        last_word = o_ddr_data;
        got++;
      end
      hold = o_ddr_valid && !i_ddr_ready;
      hold_data = o_ddr_data;
      @(posedge clk); #1;
      cyc++;
      if (words > 0 && got == words) break;
    end
    chk({tag, "_word_count"}, got, words);
    chk({tag, "_read_count"}, next_addr, n);
    chk({tag, "_done_end"}, o_done, 1'b1);
    chk({tag, "_valid_end"}, o_ddr_valid, 1'b0);
    $display("xfer %s n=%0d mode=%0h sel=%0d words=%0d/%0d reads=%0d cycles=%0d",
             tag, n, mode, sel, got, words, next_addr, cyc);
  endtask

  typedef struct {
    int         n;
    logic [3:0] mode;
    int         sel;
    int         pct;
    int         words;
  } vec_t;

  vec_t vecs [7];
  logic [DDR_W-1:0] lw [7];

  initial begin
    vecs[0] = '{n: 2*B,   mode: 4'b0000, sel: 3, pct: 100, words: 2};
    vecs[1] = '{n: B+1,   mode: 4'b0000, sel: 3, pct: 100, words: 2};
    vecs[2] = '{n: B,     mode: 4'b0010, sel: 5, pct: 100, words: 1};
    vecs[3] = '{n: 255,   mode: 4'b0000, sel: 7, pct: 50,  words: 16};
    vecs[4] = '{n: 0,     mode: 4'b0000, sel: 3, pct: 100, words: 0};
    vecs[5] = '{n: 1,     mode: 4'b0000, sel: 9, pct: 100, words: 1};
    vecs[6] = '{n: 3*B,   mode: 4'b1011, sel: 7, pct: 70,  words: 3};

    for (int p = 0; p < PE_NUM; p++)
      for (int k = 0; k < 256; k++) mem[p][k] = $urandom;
    for (int k = 0; k < 256; k++) begin
      mem[3][k] = k;
      mem[5][k] = 32'hAAAA_5555;
    end

    rst = 1'b1; i_start = 1'b0; i_conf_mode = '0; i_conf_idx_num = '0; i_conf_pe_sel = '0;
    i_ddr_ready = 1'b0; i_idx_rd_data = '0; last_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", o_done, 1'b1);
    chk("reset_valid", o_ddr_valid, 1'b0);
    chk("reset_rd_en", o_idx_rd_en, 1'b0);
    chk("reset_rd_addr", o_idx_rd_addr, '0);
    chk("reset_data", o_ddr_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      last_word = '0;
      run_xfer(vecs[i].n, vecs[i].mode, vecs[i].sel, vecs[i].pct, vecs[i].words,
               $sformatf("vec%0d", i));
      lw[i] = last_word;
    end
    chk("ramp_word2_lane0", lw[0][31:0], 32'd16);
    chk("ramp_word2_lane15", lw[0][15*E +: E], 32'd31);
    chk("partial_word2", lw[1], {480'b0, 32'd16});
    chk("swap_word", lw[2], {16{32'h5555_AAAA}});

    // Abort a running N=40 transfer with reads in flight, restart with N=5 on another PE.
    i_conf_idx_num = 8'd40; i_conf_mode = 4'b0000; i_conf_pe_sel = 5'd3;
    i_start = 1'b1; i_ddr_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("abort_busy", o_done, 1'b0);
    chk("abort_inflight", o_idx_rd_en, 1'b1);
    run_xfer(5, 4'b0000, 11, 100, 1, "abort");

    // Reset in the middle of a transfer, after a word has been emitted.
    i_conf_idx_num = 8'd40; i_conf_mode = 4'b0000; i_conf_pe_sel = 5'd7;
    i_start = 1'b1; i_ddr_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done", o_done, 1'b1);
    chk("midrst_valid", o_ddr_valid, 1'b0);
    chk("midrst_rd_en", o_idx_rd_en, 1'b0);
    chk("midrst_rd_addr", o_idx_rd_addr, '0);
    chk("midrst_data", o_ddr_data, '0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_quiet%0d", c), {o_idx_rd_en, o_ddr_valid}, 2'b00);
    end
    $display("xfer midrst reset applied and released");
    run_xfer(B + 3, 4'b0010, 7, 60, 2, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
